// File: rtl/fwd_sel_ctrl_if.sv
// rtl/fwd_sel_ctrl_if.sv - ID-stage request and operand-select response bundle for fwd_sel_ctrl
interface fwd_sel_ctrl_if #(
    parameter int RADDR_W = 4
);
    logic               id_valid_i;
    logic [RADDR_W-1:0] id_src_a_i;
    logic [RADDR_W-1:0] id_src_b_i;
    logic [RADDR_W-1:0] id_dst_i;
    logic               id_wr_en_i;
    logic               id_is_load_i;
    logic               hold_i;
    logic               flush_i;
    logic               stall_o;
    logic [1:0]         sel_a_o;
    logic [1:0]         sel_b_o;
    logic               ex_valid_o;

    modport master (
        output id_valid_i, id_src_a_i, id_src_b_i, id_dst_i, id_wr_en_i, id_is_load_i,
        output hold_i, flush_i,
        input  stall_o, sel_a_o, sel_b_o, ex_valid_o
    );

    modport slave (
        input  id_valid_i, id_src_a_i, id_src_b_i, id_dst_i, id_wr_en_i, id_is_load_i,
        input  hold_i, flush_i,
        output stall_o, sel_a_o, sel_b_o, ex_valid_o
    );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - ALU operand forwarding selects and load-use stall; FWD_R0_ZERO_EN makes r0 a hardwired zero
// Select codes: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
module fwd_sel_ctrl #(
    parameter int RADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_sel_ctrl_if.slave     bus
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b10;
    localparam logic [1:0] SEL_MWB = 2'b01;

    // WB producers are already visible through the register file, so only
    // the EX and MEM occupants can supply a forwarded operand.
    logic               ex_valid_q;
    logic               ex_wr_q;
    logic               ex_load_q;
    logic [RADDR_W-1:0] ex_dst_q;
    logic               mem_valid_q;
    logic               mem_wr_q;
    logic [RADDR_W-1:0] mem_dst_q;
    logic [1:0]         sel_a_q;
    logic [1:0]         sel_b_q;

    logic src_a_ok;
    logic src_b_ok;
    logic id_wr;

`ifdef FWD_R0_ZERO_EN
    assign src_a_ok = |bus.id_src_a_i;
    assign src_b_ok = |bus.id_src_b_i;
    assign id_wr    = bus.id_wr_en_i & (|bus.id_dst_i);
`else
    assign src_a_ok = 1'b1;
    assign src_b_ok = 1'b1;
    assign id_wr    = bus.id_wr_en_i;
`endif

    logic ex_hit_a;
    logic ex_hit_b;
    logic mem_hit_a;
    logic mem_hit_b;
    logic load_use;
    logic stall;
    logic issue;
    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;

    // ID's own destination is never compared: only older slots can produce.
    assign ex_hit_a  = ex_valid_q  & ex_wr_q  & (ex_dst_q  == bus.id_src_a_i) & src_a_ok;
    assign ex_hit_b  = ex_valid_q  & ex_wr_q  & (ex_dst_q  == bus.id_src_b_i) & src_b_ok;
    assign mem_hit_a = mem_valid_q & mem_wr_q & (mem_dst_q == bus.id_src_a_i) & src_a_ok;
    assign mem_hit_b = mem_valid_q & mem_wr_q & (mem_dst_q == bus.id_src_b_i) & src_b_ok;

    assign load_use = bus.id_valid_i & ex_load_q & (ex_hit_a | ex_hit_b);
    assign stall    = load_use & ~bus.flush_i;
    assign issue    = bus.id_valid_i & ~stall;

    always_comb begin
        sel_a_nxt = SEL_RF;
        sel_b_nxt = SEL_RF;
        if (ex_hit_a && !ex_load_q) begin
            sel_a_nxt = SEL_EXM;
        end else if (mem_hit_a) begin
            sel_a_nxt = SEL_MWB;
        end
        if (ex_hit_b && !ex_load_q) begin
            sel_b_nxt = SEL_EXM;
        end else if (mem_hit_b) begin
            sel_b_nxt = SEL_MWB;
        end
    end

    // Flush outranks hold: the branch in EX must be killed even during a memory wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_dst_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dst_q   <= '0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end else if (bus.flush_i) begin
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
        end else if (!bus.hold_i) begin
            mem_valid_q <= ex_valid_q;
            mem_wr_q    <= ex_wr_q;
            mem_dst_q   <= ex_dst_q;
            ex_valid_q  <= issue;
            ex_wr_q     <= issue & id_wr;
            ex_load_q   <= issue & bus.id_is_load_i;
            ex_dst_q    <= bus.id_dst_i;
            sel_a_q     <= issue ? sel_a_nxt : SEL_RF;
            sel_b_q     <= issue ? sel_b_nxt : SEL_RF;
        end
    end

    assign bus.stall_o    = stall;
    assign bus.sel_a_o    = sel_a_q;
    assign bus.sel_b_o    = sel_b_q;
    assign bus.ex_valid_o = ex_valid_q;
endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb/tb_fwd_sel_ctrl.sv - directed and randomized checks of fwd_sel_ctrl against an in-flight instruction model
module tb_fwd_sel_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fwd_sel_ctrl_if bus ();

    fwd_sel_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit       v;
        bit       wr;
        bit       ld;
        bit [3:0] dst;
    } rec_t;

    // flight[age]: age 0 is the instruction in EX, age 1 the one in MEM.
    rec_t       flight [2];
    logic [1:0] m_sel_a;
    logic [1:0] m_sel_b;

    function automatic bit reg_real(input bit [3:0] r);
`ifdef FWD_R0_ZERO_EN
        return r != 4'd0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit produces(input rec_t r, input bit [3:0] src);
        return r.v && r.wr && r.dst == src && reg_real(src);
    endfunction

    // Newest producer whose result already exists wins; a load has no result until MEM/WB.
    function automatic logic [1:0] model_sel(input bit [3:0] src);
        for (int age = 0; age < 2; age++) begin
            if (produces(flight[age], src)) begin
                if (age == 0 && flight[age].ld) continue;
                return (age == 0) ? 2'b10 : 2'b01;
            end
        end
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        if (!bus.id_valid_i || bus.flush_i || !flight[0].ld) return 1'b0;
        return produces(flight[0], bus.id_src_a_i) || produces(flight[0], bus.id_src_b_i);
    endfunction

    function automatic logic [5:0] model_out();
        return {model_stall(), flight[0].v, m_sel_a, m_sel_b};
    endfunction

    task automatic drive(input bit v, input bit [3:0] a, input bit [3:0] b,
                         input bit [3:0] d, input bit wr, input bit ld);
        bus.id_valid_i   = v;
        bus.id_src_a_i   = a;
        bus.id_src_b_i   = b;
        bus.id_dst_i     = d;
        bus.id_wr_en_i   = wr;
        bus.id_is_load_i = ld;
    endtask

    task automatic model_clear();
        flight[0] = '0;
        flight[1] = '0;
        m_sel_a   = 2'b00;
        m_sel_b   = 2'b00;
    endtask

    task automatic tick();
        rec_t       nf0, nf1;
        logic [1:0] na, nb;
        nf0 = flight[0];
        nf1 = flight[1];
        na  = m_sel_a;
        nb  = m_sel_b;
        if (bus.flush_i) begin
            nf0 = '0; nf1 = '0; na = 2'b00; nb = 2'b00;
        end else if (!bus.hold_i) begin
            nf1 = flight[0];
            if (bus.id_valid_i && !model_stall()) begin
                nf0 = '{v: 1'b1, wr: bus.id_wr_en_i && reg_real(bus.id_dst_i),
                        ld: bus.id_is_load_i, dst: bus.id_dst_i};
                na  = model_sel(bus.id_src_a_i);
                nb  = model_sel(bus.id_src_b_i);
            end else begin
                nf0 = '0; na = 2'b00; nb = 2'b00;
            end
        end
        @(posedge clk);
        #1;
        flight[0] = nf0;
        flight[1] = nf1;
        m_sel_a   = na;
        m_sel_b   = nb;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 4'd1, 4'd2, 4'd3, 1, 0);
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_state got=%b want=000000",
                     {bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
        do_reset();
    endtask

    task automatic test_ex_forward();
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd3, 1, 0); tick();
        drive(1, 4'd3, 4'd4, 4'd7, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 5'b1_10_00) begin
            bad++;
            $display("FAIL ex_forward got=%b want=11000", {bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
    endtask

    task automatic test_mem_forward();
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd3, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);          tick();
        drive(1, 4'd1, 4'd3, 4'd8, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 5'b1_00_01) begin
            bad++;
            $display("FAIL mem_forward got=%b want=10001", {bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
    endtask

    task automatic test_newest_wins();
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd3, 1, 0); tick();
        drive(1, 4'd4, 4'd5, 4'd3, 1, 0); tick();
        drive(1, 4'd3, 4'd3, 4'd9, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.sel_a_o, bus.sel_b_o} !== 4'b10_10) begin
            bad++;
            $display("FAIL newest_wins got=%b want=1010", {bus.sel_a_o, bus.sel_b_o});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd5, 1, 1); tick();
        drive(1, 4'd5, 4'd2, 4'd6, 1, 0);
        @(negedge clk);
        total++;
        if (bus.stall_o !== 1'b1) begin
            bad++;
            $display("FAIL load_use_stall got=%b want=1", bus.stall_o);
        end
        tick();
        @(negedge clk);
        total++;
        if ({bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 6'b0_0_00_00) begin
            bad++;
            $display("FAIL load_use_bubble got=%b want=000000",
                     {bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 5'b1_01_00) begin
            bad++;
            $display("FAIL load_use_resume got=%b want=10100", {bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd3, 1, 0); tick();
        drive(1, 4'd3, 4'd1, 4'd6, 1, 0); tick();
        drive(1, 4'd6, 4'd3, 4'd7, 1, 0);
        bus.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 6'b0_1_10_00) begin
                bad++;
                $display("FAIL hold_frozen cycle=%0d got=%b want=011000", i,
                         {bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
            end
            tick();
        end
        bus.hold_i = 1'b0;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 5'b1_10_01) begin
            bad++;
            $display("FAIL hold_resume got=%b want=11001", {bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd5, 1, 1); tick();
        drive(1, 4'd5, 4'd1, 4'd6, 1, 0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall got=%b want=0", bus.stall_o);
        end
        tick();
        bus.flush_i = 1'b0;
        drive(1, 4'd5, 4'd5, 4'd2, 1, 0);
        @(negedge clk);
        total++;
        if ({bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 6'b0) begin
            bad++;
            $display("FAIL flush_bubble got=%b want=000000",
                     {bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if ({bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 5'b1_00_00) begin
            bad++;
            $display("FAIL flush_no_match got=%b want=10000", {bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd5, 1, 1); tick();
        drive(1, 4'd2, 4'd2, 4'd6, 1, 0); tick();
        drive(1, 4'd6, 4'd6, 4'd7, 1, 1); tick();
        drive(1, 4'd7, 4'd6, 4'd8, 1, 0);
        @(negedge clk);
        total++;
        if (bus.stall_o !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_stall got=%b want=1", bus.stall_o);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o} !== 6'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=000000",
                     {bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o});
        end
        do_reset();
    endtask

    task automatic test_r0();
        logic [1:0] want;
`ifdef FWD_R0_ZERO_EN
        want = 2'b00;
`else
        want = 2'b10;
`endif
        do_reset();
        drive(1, 4'd1, 4'd2, 4'd0, 1, 0); tick();
        drive(1, 4'd0, 4'd1, 4'd4, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++;
        if (bus.sel_a_o !== want) begin
            bad++;
            $display("FAIL r0_source got=%b want=%b", bus.sel_a_o, want);
        end
    endtask

    task automatic test_random();
        logic [5:0] want;
        logic [5:0] got;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
            bus.hold_i  = $urandom_range(0, 9) == 0;
            bus.flush_i = $urandom_range(0, 19) == 0;
            @(negedge clk);
            want = model_out();
            got  = {bus.stall_o, bus.ex_valid_o, bus.sel_a_o, bus.sel_b_o};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random cycle=%0d got=%b want=%b", i, got, want);
            end
            tick();
        end
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_newest_wins();
        test_load_use();
        test_hold();
        test_flush();
        test_reset_mid_stall();
        test_r0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
